cve2_obi_wb_bridge: RTL and testbench
=====================================

Name: cve2_obi_wb_bridge

Overview:
Downstream neighbour of the cve2 core data port. Converts the core's OBI-style req/gnt/rvalid data interface into a Wishbone classic (B4, non-pipelined) master for the Caravel user-area bus. Supports one outstanding transaction, returns the response on rvalid, and maps bus errors onto data_err.

Parameters:
TimeoutCycles, 255, number of BUS-state cycles without ack/err before abort (used only with the optional feature); legal range 1..65535.

Ports:
clk_i  input  1  core clock
rst_ni  input  1  reset, asynchronous, active-low
data_req_i  input  1  request from core
data_gnt_o  output  1  grant to core
data_rvalid_o  output  1  response valid, 1-cycle pulse
data_we_i  input  1  1 = write
data_be_i  input  4  byte enables
data_addr_i  input  32  byte address
data_wdata_i  input  32  write data
data_rdata_o  output  32  read data
data_err_o  output  1  response error, valid with rvalid
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  Wishbone write enable
wbm_sel_o  output  4  Wishbone byte select
wbm_adr_o  output  32  Wishbone word-aligned address
wbm_dat_o  output  32  Wishbone write data
wbm_dat_i  input  32  Wishbone read data
wbm_ack_i  input  1  Wishbone acknowledge
wbm_err_i  input  1  Wishbone error

Behaviour:
- Single clock clk_i; reset rst_ni asynchronous, active-low. All state, including the response registers, resets asynchronously.
- Reset values: gnt 0, rvalid 0, rdata 0, err 0, cyc 0, stb 0, we 0, sel 0, adr 0, dat_o 0. Internal state IDLE, timeout counter 0.
- FSM states: IDLE, BUS.
- IDLE:
  - data_gnt_o = data_req_i (combinational). gnt is never asserted outside IDLE.
  - On req&&gnt at edge T: capture we, be, {addr[31:2],2'b00} and wdata into the wbm_* registers; cyc=stb=1 from T+1; go to BUS.
- BUS:
  - cyc, stb, we, sel, adr and dat_o stay stable until termination.
  - Termination is wbm_ack_i or wbm_err_i sampled high at an edge. On that edge: cyc=stb=0, state goes to IDLE, and data_rvalid_o=1 for exactly the next cycle.
  - data_err_o = wbm_err_i. If ack and err are both high, err wins: err_o=1, rdata_o=0.
  - data_rdata_o = wbm_dat_i for a read with ack. For writes or errors, data_rdata_o=0.
  - rdata and err hold their values until the next response.
- Latency: grant at edge T, earliest ack sampled at T+1, rvalid high in cycle T+2 (minimum 2 cycles from grant to response).
- Throughput: in the rvalid cycle the FSM is in IDLE and may grant a new request, giving one access per 2 cycles at zero wait states.
- ack/err seen while in IDLE: ignored, no rvalid.
- Address bits [1:0] are dropped. Misaligned accesses are split by the core, not here.
- Reset asserted mid-transaction: cyc/stb drop immediately (asynchronously), no rvalid is produced, and the FSM returns to IDLE.

Optional Feature:
Macro CVE2_WB_TIMEOUT_EN.
- With it:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle with no ack/err.
  - When it reaches TimeoutCycles with no termination: cyc=stb=0, rvalid pulses next cycle with err_o=1, rdata_o=0, and the FSM returns to IDLE.
  - ack/err arriving on that same edge take priority over the timeout.
- Without it: no counter is present, and BUS waits indefinitely for ack/err.

Test Plan:
- Read at addr 0x3000_0006, be=4'b1111, slave acks 1 cycle after stb with dat 0xDEADBEEF -> gnt same cycle as req; adr=0x3000_0004, sel=F, we=0; rvalid one cycle with rdata=0xDEADBEEF, err=0.
- Write at 0x3000_0010, be=4'b0011, wdata=0x1234_5678, ack after 3 wait cycles -> cyc/stb held 4 cycles with stable adr/sel/dat_o; rvalid with rdata=0, err=0.
- Two back-to-back reads, req held high, zero-wait ack -> second gnt coincides with first rvalid; responses arrive in order, one access every 2 cycles.
- Slave asserts ack and err together on a read -> rvalid with err=1, rdata=0; cyc deasserted the same edge.
- With CVE2_WB_TIMEOUT_EN, TimeoutCycles=8, slave silent -> cyc drops after 8 BUS cycles; rvalid with err=1. A later ack is ignored (no rvalid).
- rst_ni pulled low during BUS with cyc=1 -> cyc/stb/rvalid go 0 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/cve2_obi_wb_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cve2_obi_wb_bridge                                                         |
// | OBI data port (req/gnt/rvalid) to Wishbone B4 classic master, one access   |
// | in flight. Optional bus timeout: define CVE2_WB_TIMEOUT_EN.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cve2_obi_wb_bridge #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        r_rvalid;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_term;
  logic        w_timeout;
  logic [1:0]  w_unused_addr;

  assign w_term        = wbm_ack_i | wbm_err_i;
  assign w_unused_addr = data_addr_i[1:0];

`ifdef CVE2_WB_TIMEOUT_EN
  localparam logic [15:0] c_TIMEOUT = 16'(TimeoutCycles);

  logic [15:0] r_tcnt;
  logic [15:0] w_tcnt_nxt;

  // The counter sits at zero while idle, so it is already clear on BUS entry.
  assign w_tcnt_nxt = r_tcnt + 16'd1;
  assign w_timeout  = (w_tcnt_nxt == c_TIMEOUT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tcnt <= 16'd0;
    end else if (r_state == S_IDLE) begin
      r_tcnt <= 16'd0;
    end else if (!w_term) begin
      r_tcnt <= w_tcnt_nxt;
    end
  end
`else
  logic [15:0] w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = 16'(TimeoutCycles);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_sel    <= 4'd0;
      r_adr    <= 32'd0;
      r_dat    <= 32'd0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (data_req_i) begin
            r_state <= S_BUS;
            r_cyc   <= 1'b1;
            r_we    <= data_we_i;
            r_sel   <= data_be_i;
            r_adr   <= {data_addr_i[31:2], 2'b00};
            r_dat   <= data_wdata_i;
          end
        end
        S_BUS: begin
          // A slave response on the same edge as the timeout takes priority.
          if (w_term) begin
            r_state  <= S_IDLE;
            r_cyc    <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= wbm_err_i;
            r_rdata  <= (wbm_err_i || r_we) ? 32'd0 : wbm_dat_i;
          end else if (w_timeout) begin
            r_state  <= S_IDLE;
            r_cyc    <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_rdata  <= 32'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_gnt_o    = data_req_i && (r_state == S_IDLE);
  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_rdata;
  assign data_err_o    = r_err;
  assign wbm_cyc_o     = r_cyc;
  assign wbm_stb_o     = r_cyc;
  assign wbm_we_o      = r_we;
  assign wbm_sel_o     = r_sel;
  assign wbm_adr_o     = r_adr;
  assign wbm_dat_o     = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_cve2_obi_wb_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cve2_obi_wb_bridge                                                      |
// | Directed bench with a transaction-level reference model and scoreboard.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cve2_obi_wb_bridge;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, wb_dat = 32'd0;
  logic        s_ack = 1'b0, s_err = 1'b0, man_ack = 1'b0;
  logic        wb_ack, wb_err;
  logic        gnt, rvalid, rerr, cyc, stb, wbwe;
  logic [3:0]  sel;
  logic [31:0] rdata, adr, dato;

  assign wb_ack = s_ack | man_ack;
  assign wb_err = s_err;

  always #5 clk = ~clk;

  cve2_obi_wb_bridge #(.TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rdata), .data_err_o(rerr),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(wbwe), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dato), .wbm_dat_i(wb_dat),
    .wbm_ack_i(wb_ack), .wbm_err_i(wb_err)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: mode 0 ack, 1 err, 2 ack+err, 3 silent; responds after s_wait stb cycles.
  int          s_mode = 0, s_wait = 0, s_cnt = 0;
  bit          s_addr_dat = 1'b0;
  logic [31:0] s_dat = 32'd0;

  always @(posedge clk) begin
    #1;
    s_ack = 1'b0; s_err = 1'b0; wb_dat = 32'd0;
    if (cyc && stb) begin
      if (s_cnt >= s_wait && s_mode != 3) begin
        s_ack  = (s_mode == 0 || s_mode == 2);
        s_err  = (s_mode == 1 || s_mode == 2);
        wb_dat = s_addr_dat ? {adr[15:0], 16'hC0DE} : s_dat;
        s_cnt  = 0;
      end else begin
        s_cnt++;
      end
    end else begin
      s_cnt = 0;
    end
  end

  // Reference model: at most one outstanding access; a response appears the cycle after it ends.
  bit          m_pend = 0, m_we = 0, m_rv = 0, m_err = 0;
  logic [3:0]  m_sel = 4'd0;
  logic [31:0] m_adr = 32'd0, m_dat = 32'd0, m_rdata = 32'd0;
  int          m_tcnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_we = 0; m_rv = 0; m_err = 0;
      m_sel = 4'd0; m_adr = 32'd0; m_dat = 32'd0; m_rdata = 32'd0; m_tcnt = 0;
    end else begin
      m_rv = 0;
      if (m_pend) begin
        if (wb_ack || wb_err) begin
          m_rv = 1; m_err = wb_err; m_pend = 0;
          m_rdata = (wb_err || m_we) ? 32'd0 : wb_dat;
        end else begin
          m_tcnt++;
`ifdef CVE2_WB_TIMEOUT_EN
          if (m_tcnt == TO) begin
            m_rv = 1; m_err = 1; m_rdata = 32'd0; m_pend = 0;
          end
`endif
        end
      end else if (req) begin
        m_pend = 1; m_we = we; m_sel = be; m_adr = addr & 32'hFFFF_FFFC;
        m_dat = wdata; m_tcnt = 0;
      end
    end
  end

  // Scoreboard of hand-computed responses {err, rdata}, in issue order.
  logic [32:0] exp_q[$];
  logic [32:0] e;
  int cyc_no = 0, cyc_run = 0, cyc_run_last = 0, rv_count = 0, rv_last = 0, rv_prev = 0;

  always @(posedge clk) cyc_no++;

  always @(negedge clk) begin
    chk("gnt", gnt, req && !m_pend);
    chk("cyc", cyc, m_pend);
    chk("stb", stb, m_pend);
    chk("rvalid", rvalid, m_rv);
    chk("rdata", rdata, m_rdata);
    chk("err", rerr, m_err);
    if (m_pend) begin
      chk("wbm_we", wbwe, m_we);
      chk("wbm_sel", sel, m_sel);
      chk("wbm_adr", adr, m_adr);
      chk("wbm_dat", dato, m_dat);
    end
    if (rvalid) begin
      rv_count++; rv_prev = rv_last; rv_last = cyc_no;
      chk("rvalid_expected", exp_q.size(), (exp_q.size() == 0) ? 32'd1 : exp_q.size());
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("resp_rdata", rdata, e[31:0]);
        chk("resp_err", rerr, e[32]);
      end
    end
    if (cyc) cyc_run++;
    else if (cyc_run != 0) begin cyc_run_last = cyc_run; cyc_run = 0; end
  end

  task automatic wait_gnt(output int n, output logic rv_at);
    bit ok = 0;
    n = 0; rv_at = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) begin ok = 1; rv_at = rvalid; break; end
      n++;
    end
    chk("gnt_seen", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rv(output int n);
    bit ok = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rvalid === 1'b1) begin ok = 1; break; end
      n++;
    end
    chk("rvalid_seen", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, output int n);
    logic rv_at;
    we = w; be = b; addr = a; wdata = d; req = 1'b1;
    wait_gnt(n, rv_at);
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, rc;
    logic rv_at;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);   chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0); chk("rst_err", rerr, 0);
    chk("rst_cyc", cyc, 0);   chk("rst_stb", stb, 0);
    chk("rst_we", wbwe, 0);   chk("rst_sel", sel, 0);
    chk("rst_adr", adr, 0);   chk("rst_dato", dato, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read, unaligned address
    s_mode = 0; s_wait = 0; s_dat = 32'hDEADBEEF;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    issue(1'b0, 4'hF, 32'h3000_0006, 32'd0, n);
    chk("t1_gnt_same_cycle", n, 0);
    chk("t1_adr", adr, 32'h3000_0004);
    chk("t1_sel", sel, 4'hF);
    chk("t1_we", wbwe, 0);
    wait_rv(n);
    chk("t1_latency", n, 1);
    chk("t1_cyc_len", cyc_run_last, 1);

    // Write, three wait states; slave drives non-zero data that must not leak
    s_wait = 3; s_dat = 32'hFFFF_FFFF;
    exp_q.push_back({1'b0, 32'd0});
    issue(1'b1, 4'b0011, 32'h3000_0010, 32'h1234_5678, n);
    chk("t2_dato", dato, 32'h1234_5678);
    chk("t2_sel", sel, 4'b0011);
    wait_rv(n);
    chk("t2_cyc_len", cyc_run_last, 4);

    // Back-to-back reads with req held high
    s_wait = 0; s_addr_dat = 1'b1;
    exp_q.push_back({1'b0, 32'h0020_C0DE});
    exp_q.push_back({1'b0, 32'h0024_C0DE});
    we = 1'b0; be = 4'hF; addr = 32'h3000_0020; req = 1'b1;
    wait_gnt(n, rv_at);
    addr = 32'h3000_0024;
    wait_gnt(n, rv_at);
    chk("t3_gnt_with_rvalid", rv_at, 1);
    req = 1'b0;
    wait_rv(n);
    chk("t3_spacing", rv_last - rv_prev, 2);

    // ack and err together on a read
    s_addr_dat = 1'b0; s_mode = 2; s_dat = 32'h55AA_55AA;
    exp_q.push_back({1'b1, 32'd0});
    issue(1'b0, 4'hF, 32'h3000_0030, 32'd0, n);
    wait_rv(n);
    chk("t4_latency", n, 1);
    chk("t4_cyc_len", cyc_run_last, 1);

    // err alone on a write
    s_mode = 1;
    exp_q.push_back({1'b1, 32'd0});
    issue(1'b1, 4'b1000, 32'h3000_0034, 32'hA5A5_A5A5, n);
    wait_rv(n);

    // Stray ack while idle
    s_mode = 0; rc = rv_count;
    man_ack = 1'b1; @(posedge clk); #1 man_ack = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("idle_ack_ignored", rv_count, rc);

`ifdef CVE2_WB_TIMEOUT_EN
    s_mode = 3;
    exp_q.push_back({1'b1, 32'd0});
    issue(1'b0, 4'hF, 32'h3000_0050, 32'd0, n);
    wait_rv(n);
    chk("t5_cyc_len", cyc_run_last, TO);
    rc = rv_count;
    man_ack = 1'b1; @(posedge clk); #1 man_ack = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t5_late_ack_ignored", rv_count, rc);
`endif

    // Reset in the middle of a bus cycle
    s_mode = 3;
    issue(1'b0, 4'hF, 32'h3000_0060, 32'd0, n);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t6_cyc_async", cyc, 0);
    chk("t6_stb_async", stb, 0);
    chk("t6_rvalid_async", rvalid, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    s_mode = 0; s_dat = 32'hCAFE_F00D;
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    issue(1'b0, 4'hF, 32'h3000_0064, 32'd0, n);
    chk("t6_adr", adr, 32'h3000_0064);
    wait_rv(n);
    chk("t6_latency", n, 1);

    repeat (2) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
